ysyx_22040895_pc_ctrl: RTL and testbench



---
 rtl/ysyx_22040895_pc_ctrl.sv | 154 +++++++++++++++
 tb/tb_ysyx_22040895_pc_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040895_pc_ctrl.sv
// Fetch PC owner and single-outstanding fetch sequencer: issues one IFU request at a
// time, holds the returned instruction for decode and applies branch/trap redirects.
module ysyx_22040895_pc_ctrl #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk_i_pcc,
    input  logic            rst_n_i_pcc,
    output logic            ifu_req_valid_o,
    input  logic            ifu_req_ready_i,
    output logic [XLEN-1:0] ifu_req_addr_o,
    input  logic            ifu_rsp_valid_i,
    input  logic [31:0]     ifu_rsp_inst_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [31:0]     id_inst_o,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_pc_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [31:0]     id_inst_q, id_inst_d;
    logic            req_valid_q;
    logic            id_valid_q;

    logic            flush_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] pc_inc_s;

    // Flush detection and target select; trap wins over a simultaneous redirect.
    always_comb begin
        flush_s  = trap_valid_i | redirect_valid_i;
        pc_inc_s = pc_q + PC_STEP;
        if (trap_valid_i) begin
            target_s = trap_pc_i;
        end else begin
            target_s = redirect_pc_i;
        end
    end

    // Next-state logic for the fetch sequencer.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (flush_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_REQ: begin
                if (flush_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
                // An accepted request for the old PC is already committed, so its
                // response must be discarded when it comes back.
                if (ifu_req_ready_i) begin
                    state_d = ST_WAIT;
                    kill_d  = flush_s;
                end else begin
                    state_d = ST_REQ;
                    kill_d  = kill_q;
                end
            end
            ST_WAIT: begin
                if (ifu_rsp_valid_i) begin
                    kill_d  = 1'b0;
                    state_d = ST_REQ;
                    if (flush_s) begin
                        pc_d = target_s;
                    end else if (kill_q) begin
                        pc_d = pc_q;
                    end else begin
                        state_d   = ST_HOLD;
                        id_pc_d   = pc_q;
                        id_inst_d = ifu_rsp_inst_i;
                    end
                end else if (flush_s) begin
                    kill_d  = 1'b1;
                    pc_d    = target_s;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (flush_s) begin
                    pc_d    = target_s;
                    state_d = ST_REQ;
                end else if (id_ready_i) begin
                    pc_d    = pc_inc_s;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    // State, PC and decode-side holding registers; valids are registered from the next state.
    always_ff @(posedge clk_i_pcc or negedge rst_n_i_pcc) begin
        if (!rst_n_i_pcc) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            id_pc_q     <= {XLEN{1'b0}};
            id_inst_q   <= 32'h0000_0000;
            req_valid_q <= 1'b0;
            id_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            req_valid_q <= (state_d == ST_REQ);
            id_valid_q  <= (state_d == ST_HOLD);
        end
    end

    assign ifu_req_valid_o = req_valid_q;
    assign ifu_req_addr_o  = pc_q;
    assign id_valid_o      = id_valid_q;
    assign id_pc_o         = id_pc_q;
    assign id_inst_o       = id_inst_q;

endmodule

// File: tb/tb_ysyx_22040895_pc_ctrl.sv
// Scoreboard bench for ysyx_22040895_pc_ctrl: stimulus queues expected requests,
// decode handshakes and per-cycle probes; one monitor process compares them.
module tb_ysyx_22040895_pc_ctrl;

    localparam int K_REQ_V = 0, K_REQ_A = 1, K_ID_V = 2, K_ID_PC = 3;
    localparam int K_ID_INST = 4, K_QREQ = 5, K_QID = 6;

    typedef struct packed { logic [63:0] addr; logic [7:0] gap; } req_exp_t;
    typedef struct packed { logic [63:0] pc; logic [31:0] inst; } id_exp_t;
    typedef struct { string name; int kind; logic [63:0] exp; } probe_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid_o;
    logic        ifu_req_ready_i = 1'b0;
    logic [63:0] ifu_req_addr_o;
    logic        ifu_rsp_valid_i = 1'b0;
    logic [31:0] ifu_rsp_inst_i = 32'h0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b0;
    logic [63:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        redirect_valid_i = 1'b0;
    logic [63:0] redirect_pc_i = 64'h0;
    logic        trap_valid_i = 1'b0;
    logic [63:0] trap_pc_i = 64'h0;

    req_exp_t    exp_req[$];
    id_exp_t     exp_id[$];
    probe_t      probes[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc_cnt = 0;
    int unsigned last_acc = 0;
    int          lat = 1;
    int          acc_seq = 0;
    logic [63:0] acc_addr = 64'h0;
    int          stray_req = 0;

    ysyx_22040895_pc_ctrl dut (
        .clk_i_pcc        (clk),
        .rst_n_i_pcc      (rst_n),
        .ifu_req_valid_o  (ifu_req_valid_o),
        .ifu_req_ready_i  (ifu_req_ready_i),
        .ifu_req_addr_o   (ifu_req_addr_o),
        .ifu_rsp_valid_i  (ifu_rsp_valid_i),
        .ifu_rsp_inst_i   (ifu_rsp_inst_i),
        .id_valid_o       (id_valid_o),
        .id_ready_i       (id_ready_i),
        .id_pc_o          (id_pc_o),
        .id_inst_o        (id_inst_o),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .trap_valid_i     (trap_valid_i),
        .trap_pc_i        (trap_pc_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    // IFU model: answers each accepted request after 'lat' cycles; can inject a stray response.
    always begin : ifu_model
        int          cnt;
        int          rsp_seq;
        int          stray_done;
        logic [63:0] rsp_addr;
        cnt = 0; rsp_seq = 0; stray_done = 0; rsp_addr = 64'h0;
        forever begin
            @(posedge clk); #1;
            ifu_rsp_valid_i = 1'b0;
            ifu_rsp_inst_i  = 32'h0;
            if (!rst_n) begin
                cnt     = 0;
                rsp_seq = acc_seq;
            end else begin
                if (rsp_seq != acc_seq) begin
                    rsp_seq  = acc_seq;
                    cnt      = lat;
                    rsp_addr = acc_addr;
                end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        ifu_rsp_valid_i = 1'b1;
                        ifu_rsp_inst_i  = inst_of(rsp_addr);
                    end
                end
                if (stray_done != stray_req) begin
                    stray_done      = stray_req;
                    ifu_rsp_valid_i = 1'b1;
                    ifu_rsp_inst_i  = 32'hDEAD_BEEF;
                end
            end
        end
    end

    // Monitor: evaluates queued probes and pops the scoreboard on every handshake.
    always @(negedge clk) begin : monitor
        req_exp_t    re;
        id_exp_t     ie;
        probe_t      p;
        logic [63:0] act;
        while (probes.size() != 0) begin
            p = probes.pop_front();
            case (p.kind)
                K_REQ_V:   act = {63'd0, ifu_req_valid_o};
                K_REQ_A:   act = ifu_req_addr_o;
                K_ID_V:    act = {63'd0, id_valid_o};
                K_ID_PC:   act = id_pc_o;
                K_ID_INST: act = {32'd0, id_inst_o};
                K_QREQ:    act = 64'(exp_req.size());
                K_QID:     act = 64'(exp_id.size());
                default:   act = 64'hX;
            endcase
            n_checks++;
            if (act !== p.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h", p.name, act, p.exp);
            end
        end
        if (rst_n) begin
            if (ifu_req_valid_o && ifu_req_ready_i) begin
                acc_addr = ifu_req_addr_o;
                acc_seq  = acc_seq + 1;
                n_checks++;
                if (exp_req.size() == 0) begin
                    n_fail++;
                    $display("FAIL req_unexpected: got request %h, expected none", ifu_req_addr_o);
                end else begin
                    re = exp_req.pop_front();
                    if (ifu_req_addr_o !== re.addr) begin
                        n_fail++;
                        $display("FAIL req_addr: got %h, expected %h", ifu_req_addr_o, re.addr);
                    end
                    if (re.gap != 8'd0) begin
                        n_checks++;
                        if (cyc_cnt - last_acc != 32'(re.gap)) begin
                            n_fail++;
                            $display("FAIL req_gap: got %0d cycles, expected %0d", cyc_cnt - last_acc, re.gap);
                        end
                    end
                end
                last_acc = cyc_cnt;
            end
            if (id_valid_o && id_ready_i) begin
                n_checks++;
                if (exp_id.size() == 0) begin
                    n_fail++;
                    $display("FAIL id_unexpected: got pc %h, expected none", id_pc_o);
                end else begin
                    ie = exp_id.pop_front();
                    if (id_pc_o !== ie.pc || id_inst_o !== ie.inst) begin
                        n_fail++;
                        $display("FAIL id_handshake: got %h/%h, expected %h/%h", id_pc_o, id_inst_o, ie.pc, ie.inst);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic probe(input string name, input int kind, input logic [63:0] exp);
        probe_t p;
        p.name = name; p.kind = kind; p.exp = exp;
        probes.push_back(p);
    endtask

    task automatic push_req(input logic [63:0] a, input logic [7:0] gap);
        req_exp_t e;
        e.addr = a; e.gap = gap;
        exp_req.push_back(e);
    endtask

    task automatic push_id(input logic [63:0] pc, input logic [31:0] inst);
        id_exp_t e;
        e.pc = pc; e.inst = inst;
        exp_id.push_back(e);
    endtask

    task automatic wait_hold(input string name);
        int k;
        k = 0;
        while (!id_valid_o && k < 20) begin
            cyc();
            k++;
        end
        probe(name, K_ID_V, 64'd1);
    endtask

    task automatic wait_drained(input string name);
        int k;
        k = 0;
        while ((exp_req.size() != 0 || exp_id.size() != 0) && k < 60) begin
            cyc();
            k++;
        end
        probe({name, "_req"}, K_QREQ, 64'd0);
        probe({name, "_id"}, K_QID, 64'd0);
    endtask

    initial begin : stimulus
        int k;
        repeat (2) cyc();
        probe("rst_req_valid", K_REQ_V, 64'd0);
        probe("rst_req_addr", K_REQ_A, 64'h8000_0000);
        probe("rst_id_valid", K_ID_V, 64'd0);
        probe("rst_id_pc", K_ID_PC, 64'd0);
        probe("rst_id_inst", K_ID_INST, 64'd0);
        cyc();

        // Sequential fetch, one instruction every 3 cycles.
        push_req(64'h8000_0000, 8'd0);
        push_req(64'h8000_0004, 8'd3);
        push_req(64'h8000_0008, 8'd3);
        push_req(64'h8000_000C, 8'd3);
        push_req(64'h8000_0010, 8'd3);
        push_id(64'h8000_0000, 32'h0000_0013);
        push_id(64'h8000_0004, 32'h0004_0013);
        push_id(64'h8000_0008, 32'h0008_0013);
        push_id(64'h8000_000C, 32'h000C_0013);
        ifu_req_ready_i = 1'b1;
        id_ready_i      = 1'b1;
        rst_n           = 1'b1;
        probe("idle_req_valid", K_REQ_V, 64'd0);
        cyc();
        probe("first_req_valid", K_REQ_V, 64'd1);
        probe("first_req_addr", K_REQ_A, 64'h8000_0000);
        k = 0;
        while (exp_id.size() != 0 && k < 60) begin
            cyc();
            k++;
        end
        probe("seq_id_drained", K_QID, 64'd0);
        id_ready_i = 1'b0;

        // Branch while decode stalls on 8000_0010.
        wait_hold("hold_0010");
        probe("hold_pc_0010", K_ID_PC, 64'h8000_0010);
        probe("hold_inst_0010", K_ID_INST, 64'h0010_0013);
        cyc(); cyc();
        probe("hold_stable_valid", K_ID_V, 64'd1);
        probe("hold_stable_pc", K_ID_PC, 64'h8000_0010);
        probe("hold_stable_inst", K_ID_INST, 64'h0010_0013);
        push_req(64'h8000_0100, 8'd0);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0100;
        cyc();
        redirect_valid_i = 1'b0;
        probe("br_id_valid_drop", K_ID_V, 64'd0);
        probe("br_req_valid", K_REQ_V, 64'd1);
        probe("br_req_addr", K_REQ_A, 64'h8000_0100);

        // Flush while a 3-cycle fetch of 8000_0008 is pending.
        wait_hold("hold_0100");
        probe("hold_pc_0100", K_ID_PC, 64'h8000_0100);
        lat = 3;
        push_req(64'h8000_0008, 8'd0);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0008;
        cyc();
        redirect_valid_i = 1'b0;
        cyc();
        push_req(64'h8000_0200, 8'd0);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0200;
        cyc();
        redirect_valid_i = 1'b0;
        k = 0;
        while (!ifu_req_valid_o && k < 10) begin
            probe("wait_kill_id_valid", K_ID_V, 64'd0);
            cyc();
            k++;
        end
        probe("kill_id_valid", K_ID_V, 64'd0);
        probe("kill_req_addr", K_REQ_A, 64'h8000_0200);
        repeat (3) cyc();
        push_req(64'h8000_0280, 8'd0);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0280;
        lat = 1;
        cyc();
        redirect_valid_i = 1'b0;
        probe("rspflush_id_valid", K_ID_V, 64'd0);
        probe("rspflush_req_valid", K_REQ_V, 64'd1);
        probe("rspflush_req_addr", K_REQ_A, 64'h8000_0280);

        // Trap and redirect together, then IFU backpressure with a retarget.
        wait_hold("hold_0280");
        trap_valid_i     = 1'b1;
        trap_pc_i        = 64'h8000_1000;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0300;
        ifu_req_ready_i  = 1'b0;
        cyc();
        trap_valid_i     = 1'b0;
        redirect_valid_i = 1'b0;
        probe("prio_req_valid", K_REQ_V, 64'd1);
        probe("prio_req_addr", K_REQ_A, 64'h8000_1000);
        probe("prio_id_valid", K_ID_V, 64'd0);
        cyc();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0400;
        probe("bp_c2_valid", K_REQ_V, 64'd1);
        probe("bp_c2_addr", K_REQ_A, 64'h8000_1000);
        cyc();
        redirect_valid_i = 1'b0;
        probe("bp_c3_valid", K_REQ_V, 64'd1);
        probe("bp_c3_addr", K_REQ_A, 64'h8000_0400);
        cyc();
        probe("bp_c4_valid", K_REQ_V, 64'd1);
        probe("bp_c4_addr", K_REQ_A, 64'h8000_0400);
        cyc();
        push_req(64'h8000_0400, 8'd0);
        ifu_req_ready_i = 1'b1;
        probe("bp_accept_addr", K_REQ_A, 64'h8000_0400);

        // Consume 8000_0400, then reset asynchronously while 8000_0404 is in WAIT.
        wait_hold("hold_0400");
        push_id(64'h8000_0400, 32'h0400_0013);
        push_req(64'h8000_0404, 8'd3);
        lat        = 3;
        id_ready_i = 1'b1;
        cyc();
        id_ready_i = 1'b0;
        probe("seq_0404_addr", K_REQ_A, 64'h8000_0404);
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        probe("async_req_valid", K_REQ_V, 64'd0);
        probe("async_req_addr", K_REQ_A, 64'h8000_0000);
        probe("async_id_valid", K_ID_V, 64'd0);
        probe("async_id_pc", K_ID_PC, 64'd0);
        probe("async_id_inst", K_ID_INST, 64'd0);
        ifu_req_ready_i = 1'b0;
        cyc(); cyc();
        rst_n     = 1'b1;
        stray_req = stray_req + 1;
        repeat (4) begin
            cyc();
            probe("stray_id_valid", K_ID_V, 64'd0);
        end

        // PC wraps from the top of the address space to zero.
        lat = 1;
        push_req(64'hFFFF_FFFF_FFFF_FFFC, 8'd0);
        push_req(64'h0000_0000_0000_0000, 8'd3);
        push_id(64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFC_0013);
        push_id(64'h0000_0000_0000_0000, 32'h0000_0013);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        redirect_valid_i = 1'b0;
        probe("wrap_req_addr", K_REQ_A, 64'hFFFF_FFFF_FFFF_FFFC);
        ifu_req_ready_i = 1'b1;
        id_ready_i      = 1'b1;
        wait_drained("wrap_drained");
        ifu_req_ready_i = 1'b0;
        id_ready_i      = 1'b0;
        repeat (3) cyc();
        probe("final_req_queue", K_QREQ, 64'd0);
        probe("final_id_queue", K_QID, 64'd0);
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
